alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 239 +++++++++++++++++++++++
 tb/tb_alu_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU, single-cycle arithmetic/logic ops plus iterative unsigned MUL/DIV.
// Define ALU_SEQ_MULDIV_EN to build the MUL/DIV engine; without it ops 8/9 report Err.
module alu_seq #(
   parameter int DataWidth = 8,
   parameter int FlagBits  = 4
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic [3:0]           FuncOp,
   input  logic [DataWidth-1:0] A,
   input  logic [DataWidth-1:0] B,
   input  logic [FlagBits-1:0]  IFlags,
   output logic [DataWidth-1:0] Y,
   output logic [DataWidth-1:0] YHi,
   output logic [FlagBits-1:0]  OFlags,
   output logic                 Busy,
   output logic                 Done,
   output logic                 Err
);

   localparam int W = DataWidth;
   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_SHL = 4'd5;
   localparam logic [3:0] OP_SHR = 4'd6;
   localparam logic [3:0] OP_CMP = 4'd7;
`ifdef ALU_SEQ_MULDIV_EN
   localparam logic [3:0] OP_MUL = 4'd8;
   localparam logic [3:0] OP_DIV = 4'd9;
   localparam int CntW = $clog2(W);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`else
   typedef enum logic {IDLE, DONE} state_t;
`endif

   // Flag vector layout is {V, N, C, Z}.
   function automatic logic [3:0] mk_flags(input logic [W-1:0] y, input logic c, input logic v);
      return {v, y[W-1], c, (y == '0)};
   endfunction

   state_t         state_q, state_d;
   logic [W-1:0]   y_q, yhi_q;
   logic [3:0]     flags_q;
   logic           err_q;
   logic           accept;
   logic [W:0]     sum;
   logic [W-1:0]   sc_y, sc_hi;
   logic [3:0]     sc_f;
   logic           sc_upd, sc_err, norm, c_bit, v_bit;
   logic           unused_iflags;

   assign unused_iflags = ^IFlags;
   assign accept        = (state_q == IDLE) && Start;

`ifdef ALU_SEQ_MULDIV_EN
   logic            sc_multi;
   logic [W-1:0]    hi_q, lo_q, opnd_q, hi_n, lo_n;
   logic            is_div_q;
   logic [CntW-1:0] cnt_q;
   logic            last;
   logic [W:0]      madd, dsh;
   logic [W+1:0]    dtrial;
   logic            unused_dtrial;

   assign last          = (state_q == CALC) && (cnt_q == CntW'(W - 1));
   assign unused_dtrial = dtrial[W];

   // One shift-add (MUL) or restoring (DIV) step per CALC cycle.
   always_comb begin
      madd   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      dsh    = {hi_q, lo_q[W-1]};
      dtrial = {1'b0, dsh} - {2'b00, opnd_q};
      hi_n   = madd[W:1];
      lo_n   = {madd[0], lo_q[W-1:1]};
      if (is_div_q) begin
         if (!dtrial[W+1]) begin
            hi_n = dtrial[W-1:0];
            lo_n = {lo_q[W-2:0], 1'b1};
         end else begin
            hi_n = dsh[W-1:0];
            lo_n = {lo_q[W-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset)
         cnt_q <= '0;
      else if (accept)
         cnt_q <= '0;
      else if (state_q == CALC)
         cnt_q <= cnt_q + 1'b1;
   end

   always_ff @(posedge Clk) begin
      if (accept) begin
         hi_q     <= '0;
         lo_q     <= FuncOp[0] ? A : B;
         opnd_q   <= FuncOp[0] ? B : A;
         is_div_q <= FuncOp[0];
      end else if (state_q == CALC) begin
         hi_q <= hi_n;
         lo_q <= lo_n;
      end
   end
`endif

   // Single-cycle result, evaluated against the live operands at accept.
   always_comb begin
      sum    = '0;
      c_bit  = 1'b0;
      v_bit  = 1'b0;
      norm   = 1'b1;
      sc_y   = y_q;
      sc_hi  = yhi_q;
      sc_f   = flags_q;
      sc_upd = 1'b1;
      sc_err = 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
      sc_multi = 1'b0;
`endif
      case (FuncOp)
         OP_ADD: begin
            sum   = {1'b0, A} + {1'b0, B} + (W+1)'(IFlags[1]);
            sc_y  = sum[W-1:0];
            c_bit = sum[W];
            v_bit = (A[W-1] == B[W-1]) && (sum[W-1] != A[W-1]);
         end
         OP_SUB, OP_CMP: begin
            sum   = {1'b0, A} + {1'b0, ~B} + {{W{1'b0}}, 1'b1};
            c_bit = sum[W];
            v_bit = (A[W-1] != B[W-1]) && (sum[W-1] != A[W-1]);
            if (FuncOp == OP_CMP) begin
               norm = 1'b0;
               sc_f = mk_flags(sum[W-1:0], c_bit, v_bit);
            end else begin
               sc_y = sum[W-1:0];
            end
         end
         OP_AND: sc_y = A & B;
         OP_OR:  sc_y = A | B;
         OP_XOR: sc_y = A ^ B;
         OP_SHL: begin
            sc_y  = {A[W-2:0], 1'b0};
            c_bit = A[W-1];
            v_bit = A[W-1] ^ A[W-2];
         end
         OP_SHR: begin
            sc_y  = {1'b0, A[W-1:1]};
            c_bit = A[0];
         end
`ifdef ALU_SEQ_MULDIV_EN
         OP_MUL: begin
            norm     = 1'b0;
            sc_upd   = 1'b0;
            sc_multi = 1'b1;
         end
         OP_DIV: begin
            norm = 1'b0;
            if (B == '0) begin
               sc_y  = '1;
               sc_hi = A;
               sc_f  = 4'b1100;
            end else begin
               sc_upd   = 1'b0;
               sc_multi = 1'b1;
            end
         end
`endif
         default: begin
            norm   = 1'b0;
            sc_upd = 1'b0;
            sc_err = 1'b1;
         end
      endcase
      if (norm) begin
         sc_hi = '0;
         sc_f  = mk_flags(sc_y, c_bit, v_bit);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
`ifdef ALU_SEQ_MULDIV_EN
         IDLE: if (Start) state_d = sc_multi ? CALC : DONE;
         CALC: if (last) state_d = DONE;
`else
         IDLE: if (Start) state_d = DONE;
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         y_q     <= '0;
         yhi_q   <= '0;
         flags_q <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= accept && sc_err;
         if (accept && sc_upd) begin
            y_q     <= sc_y;
            yhi_q   <= sc_hi;
            flags_q <= sc_f;
         end
`ifdef ALU_SEQ_MULDIV_EN
         else if (last) begin
            y_q     <= lo_n;
            yhi_q   <= hi_n;
            flags_q <= is_div_q ? mk_flags(lo_n, 1'b0, 1'b0)
                                : {1'b0, hi_n[W-1], (hi_n != '0), ({hi_n, lo_n} == '0)};
         end
`endif
      end
   end

   assign Y      = y_q;
   assign YHi    = yhi_q;
   assign OFlags = FlagBits'(flags_q);
   assign Busy   = (state_q != IDLE);
   assign Done   = (state_q == DONE);
   assign Err    = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq at DataWidth=8; follows ALU_SEQ_MULDIV_EN like the RTL.
module tb_alu_seq;

   localparam int W = 8;

   logic         Clk = 1'b0;
   logic         Reset, Start;
   logic [3:0]   FuncOp;
   logic [W-1:0] A, B;
   logic [3:0]   IFlags;
   logic [W-1:0] Y, YHi;
   logic [3:0]   OFlags;
   logic         Busy, Done, Err;

   alu_seq #(.DataWidth(W), .FlagBits(4)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .FuncOp(FuncOp), .A(A), .B(B),
      .IFlags(IFlags), .Y(Y), .YHi(YHi), .OFlags(OFlags), .Busy(Busy), .Done(Done), .Err(Err)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [7:0] y;
      logic [7:0] hi;
      logic [3:0] f;
      logic       err;
      int         lat;
      int         acc;
   } exp_t;

   exp_t       sbq[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc   = 0;
   logic [7:0] m_y   = '0;
   logic [7:0] m_hi  = '0;
   logic [3:0] m_f   = '0;
   logic [3:0] r_op;
   logic [7:0] r_a, r_b;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference behaviour; latency counts cycles from the cycle Start is presented.
   function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                  input logic cin);
      exp_t        e;
      logic [8:0]  s;
      logic [15:0] p;
      e.y = m_y; e.hi = m_hi; e.f = m_f; e.err = 1'b0; e.lat = 1; e.acc = 0;
      case (op)
         4'd0: begin
            s = {1'b0, a} + {1'b0, b} + {8'b0, cin};
            e.y = s[7:0]; e.hi = 8'h00;
            e.f = {(a[7] == b[7]) && (s[7] != a[7]), s[7], s[8], s[7:0] == 8'h00};
         end
         4'd1, 4'd7: begin
            s = {1'b0, a} + {1'b0, ~b} + 9'd1;
            e.f = {(a[7] != b[7]) && (s[7] != a[7]), s[7], s[8], s[7:0] == 8'h00};
            if (op == 4'd1) begin e.y = s[7:0]; e.hi = 8'h00; end
         end
         4'd2, 4'd3, 4'd4: begin
            e.y  = (op == 4'd2) ? (a & b) : (op == 4'd3) ? (a | b) : (a ^ b);
            e.hi = 8'h00;
            e.f  = {1'b0, e.y[7], 1'b0, e.y == 8'h00};
         end
         4'd5: begin
            e.y = a << 1; e.hi = 8'h00;
            e.f = {a[7] ^ e.y[7], e.y[7], a[7], e.y == 8'h00};
         end
         4'd6: begin
            e.y = a >> 1; e.hi = 8'h00;
            e.f = {1'b0, e.y[7], a[0], e.y == 8'h00};
         end
`ifdef ALU_SEQ_MULDIV_EN
         4'd8: begin
            p = 16'(a) * 16'(b);
            e.y = p[7:0]; e.hi = p[15:8];
            e.f = {1'b0, p[15], p[15:8] != 8'h00, p == 16'h0000};
            e.lat = W + 1;
         end
         4'd9: begin
            if (b == 8'h00) begin
               e.y = 8'hFF; e.hi = a; e.f = 4'b1100;
            end else begin
               e.y = a / b; e.hi = a % b;
               e.f = {1'b0, e.y[7], 1'b0, e.y == 8'h00};
               e.lat = W + 1;
            end
         end
`endif
         default: e.err = 1'b1;
      endcase
      return e;
   endfunction

   // Monitor: every Done pulse must match the oldest outstanding expectation.
   always @(negedge Clk) begin
      exp_t e;
      if (Done) begin
         if (sbq.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sbq.pop_front();
            chk("y", 32'(Y), 32'(e.y));
            chk("yhi", 32'(YHi), 32'(e.hi));
            chk("flags", 32'(OFlags), 32'(e.f));
            chk("err", 32'(Err), 32'(e.err));
            chk("latency", 32'(cyc - e.acc), 32'(e.lat));
         end
      end else if (Err) begin
         chk("err_without_done", 32'(Err), 32'd0);
      end
   end

   // Called at a negedge; returns at a negedge after the result has been scored.
   task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input int extra);
      exp_t       e;
      logic [3:0] fl;
      int         g;
      g = 0;
      while (Busy && g < 50) begin @(negedge Clk); g++; end
      if (Busy) chk("idle_timeout", 32'(Busy), 32'd0);
      fl     = 4'($urandom);
      fl[1]  = cin;
      Start  = 1'b1; FuncOp = op; A = a; B = b; IFlags = fl;
      e      = model(op, a, b, cin);
      e.acc  = cyc;
      m_y    = e.y; m_hi = e.hi; m_f = e.f;
      sbq.push_back(e);
      @(negedge Clk);
      chk("busy_after_accept", 32'(Busy), 32'd1);
      for (int i = 0; i < extra; i++) begin
         FuncOp = 4'd2; A = ~a; B = 8'hFF;
         @(negedge Clk);
      end
      Start = 1'b0;
      g = 0;
      while (sbq.size() != 0 && g < 50) begin @(negedge Clk); g++; end
      if (sbq.size() != 0) begin
         chk("done_timeout", 32'd0, 32'd1);
         sbq.delete();
      end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_y"}, 32'(Y), 32'd0);
      chk({tag, "_yhi"}, 32'(YHi), 32'd0);
      chk({tag, "_flags"}, 32'(OFlags), 32'd0);
      chk({tag, "_busy"}, 32'(Busy), 32'd0);
      chk({tag, "_done"}, 32'(Done), 32'd0);
      chk({tag, "_err"}, 32'(Err), 32'd0);
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b0; FuncOp = 4'd0; A = '0; B = '0; IFlags = '0;
      repeat (2) @(negedge Clk);
      chk_zero_outputs("reset");
      Reset = 1'b0;

      do_op(4'd0, 8'hFF, 8'h01, 1'b0, 0);
      chk("add_wrap_y", 32'(Y), 32'h00);
      chk("add_wrap_flags", 32'(OFlags), 32'b0011);
      do_op(4'd1, 8'h80, 8'h01, 1'b0, 0);
      chk("sub_ovf_y", 32'(Y), 32'h7F);
      chk("sub_ovf_flags", 32'(OFlags), 32'b1010);
      do_op(4'd3, 8'hAA, 8'h00, 1'b0, 1);
      chk("or_y", 32'(Y), 32'hAA);
      do_op(4'd7, 8'h05, 8'h05, 1'b0, 0);
      chk("cmp_y_held", 32'(Y), 32'hAA);
      chk("cmp_flags", 32'(OFlags), 32'b0011);
      do_op(4'hF, 8'h12, 8'h34, 1'b1, 0);
      chk("unknown_y_held", 32'(Y), 32'hAA);
      chk("unknown_flags_held", 32'(OFlags), 32'b0011);
      do_op(4'd0, 8'h7F, 8'h00, 1'b1, 0);
      chk("add_cin_y", 32'(Y), 32'h80);
      chk("add_cin_flags", 32'(OFlags), 32'b1100);
      do_op(4'd5, 8'h40, 8'h00, 1'b0, 0);
      chk("shl_flags", 32'(OFlags), 32'b1100);
`ifdef ALU_SEQ_MULDIV_EN
      do_op(4'd8, 8'hFF, 8'hFF, 1'b0, 4);
      chk("mul_y", 32'(Y), 32'h01);
      chk("mul_yhi", 32'(YHi), 32'hFE);
      chk("mul_flags", 32'(OFlags), 32'b0110);
      do_op(4'd9, 8'hC8, 8'h07, 1'b0, 0);
      chk("div_y", 32'(Y), 32'h1C);
      chk("div_yhi", 32'(YHi), 32'h04);
      do_op(4'd9, 8'hC8, 8'h00, 1'b0, 0);
      chk("div0_y", 32'(Y), 32'hFF);
      chk("div0_yhi", 32'(YHi), 32'hC8);
      chk("div0_flags", 32'(OFlags), 32'b1100);
`else
      do_op(4'd8, 8'hFF, 8'hFF, 1'b0, 0);
      chk("mul_off_y_held", 32'(Y), 32'h80);
      do_op(4'd9, 8'hC8, 8'h07, 1'b0, 1);
      chk("div_off_flags_held", 32'(OFlags), 32'b1100);
`endif

      for (int i = 0; i < 40; i++) begin
         r_op = 4'($urandom_range(0, 15));
         r_a  = 8'($urandom);
         r_b  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         do_op(r_op, r_a, r_b, 1'($urandom), int'($urandom_range(0, 1)));
      end

      // Reset wins over a simultaneous Start.
      Start = 1'b1; FuncOp = 4'd0; A = 8'h11; B = 8'h22; Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0; Start = 1'b0;
      m_y = '0; m_hi = '0; m_f = '0;
      chk_zero_outputs("reset_vs_start");
      repeat (3) @(negedge Clk);

`ifdef ALU_SEQ_MULDIV_EN
      // Abort a multiply mid-iteration.
      Start = 1'b1; FuncOp = 4'd8; A = 8'hFF; B = 8'hFF;
      @(negedge Clk);
      Start = 1'b0;
      repeat (3) @(negedge Clk);
      chk("busy_in_calc", 32'(Busy), 32'd1);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      chk_zero_outputs("reset_in_calc");
      do_op(4'd0, 8'h01, 8'h02, 1'b0, 0);
      chk("post_reset_add_y", 32'(Y), 32'h03);
      repeat (12) @(negedge Clk);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
